alu_op_sequencer: RTL and testbench

- Command-driven controller that sits in front of alu_8bit and drives its A/B/Opcode inputs.
- Holds an 8-bit accumulator used as operand A; each command supplies operand B as an immediate.
- Issues one ALU operation per command and captures Result/Carry/Zero/Overflow back into the accumulator and flag register.
- Returns a response over a valid/ready handshake, turning the combinational ALU into a sequenced, software-visible execution unit.

---
 rtl/alu_op_sequencer.sv | 111 +++++++++++
 tb/tb_alu_op_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer for alu_8bit: holds the accumulator (operand A), issues one
// ALU operation per command, captures result and flags, and returns a handshaked response.
module alu_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'b1000;

  state_t     state, state_next;
  logic [3:0] op_q;
  logic [2:0] flags;
  logic       err;
  logic       cmd_fire;
  logic       rsp_fire;

  assign cmd_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  assign rsp_data  = acc;
  assign rsp_flags = flags;
  assign rsp_err   = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // alu_b doubles as the registered immediate; LOAD presents opcode 0000 to the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      acc        <= '0;
      flags      <= '0;
      err        <= 1'b0;
      op_count   <= '0;
    end else begin
      if (cmd_fire) begin
        op_q       <= cmd_op;
        alu_a      <= acc;
        alu_b      <= cmd_imm;
        alu_opcode <= (cmd_op == OP_LOAD) ? 4'b0000 : cmd_op;
      end

      if (state == EXEC) begin
        if (!op_q[3]) begin
          acc   <= alu_result;
          flags <= {alu_carry, alu_overflow, alu_zero};
        end else if (op_q == OP_LOAD) begin
          acc   <= alu_b;
          flags <= {1'b0, 1'b0, (alu_b == '0)};
        end else begin
          err <= 1'b1;
        end
      end

      if (rsp_fire) begin
        err <= 1'b0;
        if (!err && (op_count != '1)) begin
          op_count <= op_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural alu_8bit stand-in and a
// response scoreboard fed at command acceptance.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_imm;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic [7:0]  acc;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .acc(acc), .op_count(op_count)
  );

  // Returns {result[7:0], carry, overflow, zero}; SUB carry is the borrow out.
  function automatic logic [10:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    logic       v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                  v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'd7: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = '0;
    endcase
    return {r, c, v, (r == 8'h00)};
  endfunction

  assign {alu_result, alu_carry, alu_overflow, alu_zero} = alu_model(alu_opcode, alu_a, alu_b);

  typedef struct {
    logic [7:0] data;
    logic [2:0] flags;
    logic       err;
  } rsp_t;

  rsp_t       sb[$];
  logic [7:0] m_acc;
  logic [2:0] m_flags;
  int         m_cnt;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
  endtask

  // Called in an IDLE cycle at the falling edge; returns in IDLE after the handshake.
  task automatic do_cmd(input logic [3:0] op, input logic [7:0] imm, input int stall);
    logic [10:0] r;
    rsp_t        e;
    rsp_t        got;
    cmd_op = op; cmd_imm = imm; cmd_valid = 1'b1;
    wait_ready();
    e.data = m_acc; e.flags = m_flags; e.err = 1'b0;
    if (op <= 4'd7) begin
      r = alu_model(op, m_acc, imm);
      e.data = r[10:3]; e.flags = r[2:0];
    end else if (op == 4'd8) begin
      e.data = imm; e.flags = {2'b00, (imm == 8'h00)};
    end else begin
      e.err = 1'b1;
    end
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (stall > 0) rsp_ready = 1'b0;
    chk("exec_alu_a", alu_a, m_acc);
    chk("exec_alu_b", alu_b, imm);
    chk("exec_alu_opcode", alu_opcode, (op == 4'd8) ? 4'd0 : op);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("latency_rsp_valid", rsp_valid, 1);
    got = sb.pop_front();
    chk("rsp_data", rsp_data, got.data);
    chk("rsp_flags", rsp_flags, got.flags);
    chk("rsp_err", rsp_err, got.err);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_data", rsp_data, got.data);
      chk("stall_rsp_flags", rsp_flags, got.flags);
      chk("stall_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    m_acc = got.data;
    m_flags = got.flags;
    if (!got.err && m_cnt < 65535) m_cnt++;
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_acc", acc, m_acc);
    chk("idle_op_count", op_count, m_cnt);
    chk("idle_rsp_err", rsp_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int cnt_before;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_imm = '0; rsp_ready = 1'b1;
    m_acc = '0; m_flags = '0; m_cnt = 0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_acc", acc, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_ports", {alu_a, alu_b, alu_opcode}, 0);
    chk("reset_rsp_fields", {rsp_data, rsp_flags, rsp_err}, 0);
    rst = 1'b0;
    #1;
    chk("post_reset_cmd_ready", cmd_ready, 1);

    do_cmd(4'd8, 8'd10, 0);
    chk("tp_load10", acc, 8'h0A);
    do_cmd(4'd0, 8'd20, 0);
    chk("tp_add20", acc, 8'h1E);
    chk("tp_add20_flags", rsp_flags, 3'b000);
    chk("tp_count2", op_count, 2);

    do_cmd(4'd8, 8'h7F, 0);
    do_cmd(4'd0, 8'h01, 0);
    chk("tp_ovf_acc", acc, 8'h80);
    chk("tp_ovf_flags", rsp_flags, 3'b010);

    do_cmd(4'd8, 8'hAA, 0);
    do_cmd(4'd4, 8'h55, 0);
    chk("tp_xor", acc, 8'hFF);
    do_cmd(4'd5, 8'h00, 0);
    chk("tp_not", acc, 8'h00);
    chk("tp_not_zero", rsp_flags[0], 1);
    do_cmd(4'd6, 8'h00, 0);
    chk("tp_shl0", acc, 8'h00);
    do_cmd(4'd7, 8'h00, 0);
    chk("tp_shr0", acc, 8'h00);

    do_cmd(4'd8, 8'h0F, 0);
    do_cmd(4'd6, 8'h00, 0);
    chk("tp_shl", acc, 8'h1E);
    do_cmd(4'd7, 8'h00, 0);
    chk("tp_shr", acc, 8'h0F);

    do_cmd(4'd8, 8'd10, 0);
    do_cmd(4'd1, 8'd20, 5);
    chk("tp_sub", acc, 8'hF6);
    chk("tp_sub_flags", rsp_flags, 3'b100);

    do_cmd(4'd8, 8'h33, 0);
    cnt_before = m_cnt;
    do_cmd(4'hB, 8'h12, 0);
    chk("tp_illegal_acc", acc, 8'h33);
    chk("tp_illegal_flags", rsp_flags, 3'b000);
    chk("tp_illegal_count", op_count, cnt_before);

    do_cmd(4'd8, 8'd5, 0);
    cmd_op = 4'd0; cmd_imm = 8'd3; cmd_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_exec_alu_a", alu_a, 8'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_acc", acc, 0);
    chk("abort_op_count", op_count, 0);
    chk("abort_cmd_ready_in_rst", cmd_ready, 0);
    rst = 1'b0;
    m_acc = '0; m_flags = '0; m_cnt = 0;
    sb.delete();
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_no_rsp", rsp_valid, 0);

    do_cmd(4'd8, 8'h44, 0);
    chk("after_abort_count", op_count, 1);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
